// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int REG_DATA_W       = 32;
    localparam int REG_COUNT        = 1 << REG_ADDR_W;
    localparam int WB_DEPTH_DEFAULT = 2;
    localparam int WB_ENTRY_W       = REG_ADDR_W + REG_DATA_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One buffered long-unit result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot mask selecting a single register in the pending vector.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [REG_COUNT-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small circular FIFO buffering long-unit results until the write port is free.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    parameter int WIDTH = WB_ENTRY_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values for the requested push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback and buffered long-unit results into the single
// register-file write port, and tracks per-register pending long-unit results.
//
// Handshake: a long-unit result transfers at a posedge where luValid && luReady.
// luReady reflects only current occupancy (never the same-cycle pop), so a full
// FIFO never sees a push. The pipeline has no handshake: it always wins the port.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] pipeAddress,
    input  logic [REG_DATA_W-1:0] pipeData,
    input  logic                  pipeWrite,
    input  logic                  issueValid,
    input  logic [REG_ADDR_W-1:0] issueAddress,
    input  logic                  luValid,
    input  logic [REG_ADDR_W-1:0] luAddress,
    input  logic [REG_DATA_W-1:0] luData,
    output logic                  luReady,
    output logic                  shouldWrite,
    output logic [REG_ADDR_W-1:0] writeAddress,
    output logic [REG_DATA_W-1:0] writeData,
    output logic [REG_COUNT-1:0]  pending,
    output logic                  hazardError
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    wb_entry_t            fifo_head;
    wb_entry_t            fifo_in;

    logic                 pipe_sel;
    logic                 lu_accept;
    logic                 issue_set;
    logic                 err_event;

    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic                 err_q, err_d;

    // A pipe write to r0 is no write at all, so it leaves the port to the FIFO.
    assign pipe_sel  = reset && pipeWrite && (pipeAddress != ZERO_REG);
    assign luReady   = reset && !fifo_full;
    assign lu_accept = luValid && luReady;
    // Results for r0 are swallowed at the input; they never occupy an entry.
    assign fifo_push = lu_accept && (luAddress != ZERO_REG);
    assign fifo_pop  = reset && !pipe_sel && !fifo_empty;
    assign issue_set = issueValid && (issueAddress != ZERO_REG);
    assign fifo_in   = '{addr: luAddress, data: luData};

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_in),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Write-port mux: pipeline first, then the FIFO head, otherwise idle.
    always_comb begin
        shouldWrite  = 1'b0;
        writeAddress = ZERO_REG;
        writeData    = '0;
        if (pipe_sel) begin
            shouldWrite  = 1'b1;
            writeAddress = pipeAddress;
            writeData    = pipeData;
        end else if (fifo_pop) begin
            shouldWrite  = 1'b1;
            writeAddress = fifo_head.addr;
            writeData    = fifo_head.data;
        end
    end

    // Scoreboard update: commit clears, issue sets, and a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d = pending_d & ~reg_onehot(fifo_head.addr);
        end
        if (issue_set) begin
            pending_d = pending_d | reg_onehot(issueAddress);
        end
        pending_d[0] = 1'b0;
    end

    // Protocol checks against the scoreboard as it stands this cycle.
    // A discarded r0 result is not a stray result: r0 is never tracked.
    always_comb begin
        err_event = 1'b0;
        if (pipe_sel && pending_q[pipeAddress]) begin
            err_event = 1'b1;
        end
        if (issue_set && pending_q[issueAddress]) begin
            err_event = 1'b1;
        end
        if (fifo_push && !pending_q[luAddress]) begin
            err_event = 1'b1;
        end
        err_d = err_q | err_event;
    end

    // Scoreboard and sticky error registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending     = pending_q;
    assign hazardError = err_q;

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges register-file write requests from the in-order pipeline writeback and from the long-latency unit (multiply/divide) into the single write port of the register file. Long-unit results are buffered in a small FIFO and drained only in cycles where the pipeline is not writing. A per-register pending scoreboard is exported to the hazard unit so that dependent instructions stall until a long-unit result has committed.

## Interface
- `DEPTH`, default 2: long-unit result FIFO entries; power of two, ≥2.
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `pipeAddress`, `pipeData` in 5/32: pipeline writeback destination and value.
- `pipeWrite` in 1: pipeline writeback request, always accepted.
- `issueValid`, `issueAddress` in 1/5: a long-unit op with destination `issueAddress` is issued this cycle.
- `luValid`, `luAddress`, `luData` in 1/5/32: long-unit result offered.
- `luReady` out 1: FIFO can accept a result; transfer when `luValid && luReady` at posedge.
- `shouldWrite`, `writeAddress`, `writeData` out 1/5/32: register-file write port, combinational.
- `pending` out 32: bit r = long-unit result for register r outstanding; bit 0 always 0.
- `hazardError` out 1: sticky protocol-violation flag.

## Operation
- Port select, per cycle:
  - If `pipeWrite && pipeAddress != 0`, drive the pipe request.
  - Else, if the FIFO is non-empty, drive the FIFO head and pop it at posedge.
  - Else, `shouldWrite = 0`.
- Pipe write to register 0: treated as idle; the FIFO may drain in that cycle.
- Enqueue: on `luValid && luReady`; a result with `luAddress == 0` is accepted and discarded, not enqueued.
- `luReady = !full` when out of reset; 0 while `reset == 0`.
- A simultaneous pop and push when full is not permitted. `luReady` depends only on current occupancy, not on the same-cycle pop.
- No bypass: an accepted result commits no earlier than the next cycle.
- Scoreboard:
  - `issueValid && issueAddress != 0` sets `pending[issueAddress]`.
  - A FIFO-sourced write clears `pending[writeAddress]`.
  - Set and clear of the same register in one cycle: set wins.
- `hazardError` is set, and held until reset, when any of these occurs:
  - the pipe writes a register whose pending bit is set;
  - an issue targets an already-pending register;
  - a result arrives for a register whose pending bit is clear.
- Reset mid-operation: the FIFO is flushed, `pending` = 0, `hazardError` = 0. In-flight results are lost; clearing them is the core's responsibility.
- Reset values: `shouldWrite` 0, `writeAddress` 0, `writeData` 0, `luReady` 0 during reset and 1 after, `pending` 0, `hazardError` 0.

## Timing
- Write-port outputs are combinational from the inputs and the FIFO head. The register file captures them on the following negedge of the same cycle.
- Result accepted at posedge N: earliest commit is in cycle N+1. Each cycle with a pipe write to a nonzero register adds one cycle of delay.
- The pending bit rises at the posedge after the issue cycle and falls at the posedge ending the commit cycle.
- FIFO pointers wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH)+1` bits.

## Structure
- Shared package holds:
  - `REG_ADDR_W` = 5, `REG_DATA_W` = 32;
  - `ZERO_REG` = 0;
  - the default for `DEPTH`.
- Sub-module `wb_fifo`:
  - parameterised depth/width, storing {address, data} = 37 bits;
  - push/pop/full/empty/head;
  - asynchronous active-low reset of pointers and count.
- The arbiter mux, scoreboard and error logic live in the top level.

## Test plan
- **Pipe only:** `pipeWrite=1`, addr 5, data 0x1234 → same cycle `shouldWrite=1`, `writeAddress=5`, `writeData=0x1234`. Addr 0 → `shouldWrite=0`.
- **Long-unit drain:**
  - Issue r7 → `pending[7]=1` next cycle.
  - Result r7 = 0xDEADBEEF accepted at posedge N; pipe idle → write r7 in cycle N+1, `pending[7]=0` after posedge N+1.
- **Contention:**
  - FIFO holds r3 = 0xA; pipe writes r4 for 3 cycles → r4 is written each cycle, r3 is written in the 4th cycle.
  - With DEPTH=2 and 2 entries queued → `luReady=0` until the first pop.
- **Zero handling:**
  - Result with `luAddress=0` → accepted, never written, FIFO count unchanged.
  - Pipe write to r0 while the FIFO is non-empty → the FIFO head drains that cycle.
- **Errors:**
  - Issue r9 twice → `hazardError=1`, sticky.
  - Pipe write to pending r9 → `hazardError=1`.
  - Result for a non-pending register → `hazardError=1`.
- **Reset mid-operation:** 2 entries queued, `pending=0x00000088`, `reset` pulsed low asynchronously → immediately FIFO empty, `pending=0`, `shouldWrite=0`, `luReady=0`; `luReady=1` after release.
